// File: rtl/sum_dump_sat.sv
// Integrate-and-dump: sums DUMP_LEN valid samples, then rounds,
// shifts and saturates each frame total to OUT_W bits.
module sum_dump_sat #(
   parameter int IN_W     = 26,
   parameter int ACC_W    = 32,
   parameter int OUT_W    = 16,
   parameter int DUMP_LEN = 16,
   parameter int SHIFT    = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        in_valid,
   input  logic signed [IN_W-1:0]      in_data,
   output logic                        out_valid,
   output logic signed [OUT_W-1:0]     out_data,
   output logic                        out_sat,
   output logic [$clog2(DUMP_LEN)-1:0] frame_pos
);

   localparam int FP_W = $clog2(DUMP_LEN);
   localparam logic [FP_W-1:0] LAST_POS = FP_W'(DUMP_LEN - 1);
   localparam logic [FP_W-1:0] ONE_POS  = FP_W'(1);
   localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);

   logic signed [ACC_W-1:0] r_acc;
   logic [FP_W-1:0]         r_pos;
   logic signed [ACC_W-1:0] r_dump;
   logic                    r_dump_v;
   logic signed [OUT_W-1:0] r_res;
   logic                    r_res_sat;
   logic                    r_res_v;
   logic signed [OUT_W-1:0] r_out_data;
   logic                    r_out_sat;
   logic                    r_out_v;

   logic                    w_acc_en;
   logic                    w_last;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W:0]   w_rnd_sum;
   logic signed [ACC_W:0]   w_r;
   logic                    w_fits;
   logic signed [OUT_W-1:0] w_res;
   logic                    w_sat;

   assign w_acc_en = in_valid && !clear;
   assign w_last   = w_acc_en && (r_pos == LAST_POS);
   assign w_sum    = r_acc + {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

   // One guard bit keeps the rounding add from wrapping.
   assign w_rnd_sum = {r_dump[ACC_W-1], r_dump} + HALF;
   assign w_r       = w_rnd_sum >>> SHIFT;
   assign w_fits    = (&w_r[ACC_W:OUT_W-1]) || !(|w_r[ACC_W:OUT_W-1]);

   always_comb begin
      w_res = w_r[OUT_W-1:0];
      w_sat = 1'b0;
      if (!w_fits) begin
         w_sat = 1'b1;
         w_res = w_r[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                            : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_pos    <= '0;
         r_dump   <= '0;
         r_dump_v <= 1'b0;
      end else if (clear) begin
         r_acc    <= '0;
         r_pos    <= '0;
         r_dump_v <= 1'b0;
      end else begin
         r_dump_v <= w_last;
         if (w_last) begin
            r_dump <= w_sum;
            r_acc  <= '0;
            r_pos  <= '0;
         end else if (w_acc_en) begin
            r_acc <= w_sum;
            r_pos <= r_pos + ONE_POS;
         end
      end
   end

   // Round/saturate stage, then the held output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res      <= '0;
         r_res_sat  <= 1'b0;
         r_res_v    <= 1'b0;
         r_out_data <= '0;
         r_out_sat  <= 1'b0;
         r_out_v    <= 1'b0;
      end else if (clear) begin
         r_res_v <= 1'b0;
         r_out_v <= 1'b0;
      end else begin
         r_res_v <= r_dump_v;
         r_out_v <= r_res_v;
         if (r_dump_v) begin
            r_res     <= w_res;
            r_res_sat <= w_sat;
         end
         if (r_res_v) begin
            r_out_data <= r_res;
            r_out_sat  <= r_res_sat;
         end
      end
   end

   assign out_valid = r_out_v;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign frame_pos = r_pos;

endmodule

// File: tb/tb_sum_dump_sat.sv
// Directed bench for sum_dump_sat: table-driven frames plus
// hand-written gap, clear and reset sequences.
module tb_sum_dump_sat;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               clear;
   logic               in_valid;
   logic signed [25:0] in_data;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               out_sat;
   logic [3:0]         frame_pos;

   sum_dump_sat dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .frame_pos (frame_pos)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cyc;
      logic signed [15:0] d;
      logic             s;
   } ev_t;

   typedef struct {
      logic signed [25:0] fill;
      logic signed [25:0] last;
      int                 exp_d;
      int                 exp_s;
   } vec_t;

   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;
   int  last_cyc;
   int  last_a;
   ev_t q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk)
      if (rst_n && out_valid) q.push_back('{cyc, out_data, out_sat});

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic send(input logic signed [25:0] v, input int gap);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      last_cyc = cyc;
   endtask

   task automatic frame(input logic signed [25:0] fill,
                        input logic signed [25:0] lastv,
                        input int maxgap);
      for (int i = 0; i < 15; i++) send(fill, $urandom_range(maxgap));
      send(lastv, $urandom_range(maxgap));
   endtask

   task automatic expect_pulse(input string nm, input int lc,
                               input int exp_d, input int exp_s);
      ev_t e;
      int  t = 0;
      while (q.size() == 0 && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (q.size() == 0) begin
         chk({nm, "_timeout"}, 0, 1);
      end else begin
         e = q.pop_front();
         chk({nm, "_lat"}, e.cyc, lc + 2);
         chk({nm, "_data"}, int'(e.d), exp_d);
         chk({nm, "_sat"}, int'(e.s), exp_s);
      end
   endtask

   task automatic expect_none(input string nm, input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      chk(nm, q.size(), 0);
      q.delete();
   endtask

   vec_t vt[7];

   initial begin
      vt[0] = '{26'sd100, 26'sd100, 100, 0};
      vt[1] = '{26'sd33554431, 26'sd33554431, 32767, 1};
      vt[2] = '{-26'sd33554432, -26'sd33554432, -32768, 1};
      vt[3] = '{26'sd0, 26'sd8, 1, 0};
      vt[4] = '{26'sd0, 26'sd7, 0, 0};
      vt[5] = '{26'sd0, -26'sd8, 0, 0};
      vt[6] = '{26'sd0, -26'sd9, -1, 0};

      rst_n    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_sat", int'(out_sat), 0);
      chk("rst_pos", int'(frame_pos), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         frame(vt[i].fill, vt[i].last, 0);
         expect_pulse($sformatf("vec%0d", i), last_cyc,
                      vt[i].exp_d, vt[i].exp_s);
         chk($sformatf("vec%0d_pos", i), int'(frame_pos), 0);
      end
      expect_none("vec_extra", 3);

      // Gapped frame followed by a back-to-back frame.
      for (int i = 0; i < 16; i++) send(26'sd5, $urandom_range(3));
      last_a = last_cyc;
      for (int i = 0; i < 16; i++) send(-26'sd5, 0);
      expect_pulse("gap5", last_a, 5, 0);
      expect_pulse("b2b", last_cyc, -5, 0);
      expect_none("b2b_extra", 3);

      // Abort mid-frame; clear beats a simultaneous sample.
      for (int i = 0; i < 10; i++) send(26'sd1000, 0);
      chk("pre_clr_pos", int'(frame_pos), 10);
      in_valid = 1'b1;
      in_data  = 26'sd9999;
      clear    = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("clr_pos", int'(frame_pos), 0);
      chk("clr_hold", int'(out_data), -5);
      for (int i = 0; i < 16; i++) send(26'sd1, 0);
      expect_pulse("after_clr", last_cyc, 1, 0);
      expect_none("clr_extra", 3);

      // Clear in the cycle after the dump drops the result.
      frame(26'sd100, 26'sd100, 0);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      expect_none("clr_t1", 5);
      chk("clr_t1_hold", int'(out_data), 1);

      // Asynchronous reset mid-frame.
      for (int i = 0; i < 5; i++) send(26'sd500, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_data", int'(out_data), 0);
      chk("arst_pos", int'(frame_pos), 0);
      chk("arst_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete();
      for (int i = 0; i < 16; i++) send(26'sd2, 0);
      expect_pulse("post_rst", last_cyc, 2, 0);
      expect_none("post_rst_extra", 3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
